// File: rtl/fp_stream_accum.sv
// fp_stream_accum: sums a packet of FP32 values from a valid/ready stream.
// One combinational AddSub does all the arithmetic; only registered state
// drives it, so there is no combinational path from in_* to sum_*.
// AddSub (defined below): FP32 add/subtract with round-to-nearest-even,
// flush-to-zero of subnormal inputs and results, and the fixed NaN 7FAAAAAA.

module fp_stream_accum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [31:0]      sum_out,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_nan,
  output logic             sum_inf
);

  typedef enum logic [1:0] {ACC, ADD, OUT} state_t;

  state_t           state_reg;
  logic [31:0]      acc_reg;
  logic [31:0]      opnd_reg;
  logic             sub_reg;
  logic             last_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             nan_reg;
  logic             inf_reg;
  logic             in_ready_reg;
  logic             sum_valid_reg;
  logic [31:0]      add_out;
  logic             add_nan;
  logic             add_inf;

  AddSub u_addsub (
    .inA (acc_reg),
    .inB (opnd_reg),
    .op  (sub_reg),
    .out (add_out)
  );

  // Element counter saturates instead of wrapping; arithmetic is unaffected.
  assign count_next = (&count_reg) ? count_reg : count_reg + 1'b1;
  assign add_nan    = (add_out[30:23] == 8'hFF) && (add_out[22:0] != 23'd0);
  assign add_inf    = (add_out[30:23] == 8'hFF) && (add_out[22:0] == 23'd0);

  // Control FSM plus datapath registers; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACC;
      acc_reg       <= 32'h0000_0000;
      opnd_reg      <= 32'h0000_0000;
      sub_reg       <= 1'b0;
      last_reg      <= 1'b0;
      count_reg     <= '0;
      nan_reg       <= 1'b0;
      inf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      sum_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (in_valid) begin
            opnd_reg     <= in_data;
            sub_reg      <= in_sub;
            last_reg     <= in_last;
            in_ready_reg <= 1'b0;
            state_reg    <= ADD;
          end
        end
        ADD: begin
          acc_reg   <= add_out;
          count_reg <= count_next;
          nan_reg   <= nan_reg | add_nan;
          inf_reg   <= inf_reg | add_inf;
          if (last_reg) begin
            sum_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end else begin
            in_ready_reg <= 1'b1;
            state_reg    <= ACC;
          end
        end
        OUT: begin
          // Result holds until taken; taking it clears the packet state.
          if (sum_ready) begin
            acc_reg       <= 32'h0000_0000;
            count_reg     <= '0;
            nan_reg       <= 1'b0;
            inf_reg       <= 1'b0;
            sum_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ACC;
          end
        end
        default: begin
          sum_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ACC;
        end
      endcase
    end
  end

  // The running accumulator doubles as the result register.
  assign in_ready  = in_ready_reg;
  assign sum_valid = sum_valid_reg;
  assign sum_out   = acc_reg;
  assign sum_count = count_reg;
  assign sum_nan   = nan_reg;
  assign sum_inf   = inf_reg;

endmodule

// AddSub: combinational FP32 out = inA + inB (op=0) or inA - inB (op=1).
module AddSub (
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        op,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN = 32'h7FAA_AAAA;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        swap;
  logic        sx, sy;
  logic [7:0]  ex, ey, d;
  logic [23:0] mx, my;
  logic [55:0] wide_sh;
  logic [26:0] al;
  logic [27:0] sum;
  logic [26:0] diff;
  logic        eff_sub;
  logic [4:0]  lz;
  logic [26:0] n;
  logic [9:0]  e;
  logic        inc;
  logic [24:0] mant;
  logic [9:0]  e_r;
  logic [22:0] frac;

  assign sa = inA[31];
  assign sb = inB[31] ^ op;
  assign ea = inA[30:23];
  assign eb = inB[30:23];
  assign fa = inA[22:0];
  assign fb = inB[22:0];

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  // Larger magnitude goes first so the subtraction never goes negative.
  assign swap = inB[30:0] > inA[30:0];
  assign sx   = swap ? sb : sa;
  assign sy   = swap ? sa : sb;
  assign ex   = swap ? eb : ea;
  assign ey   = swap ? ea : eb;
  assign mx   = swap ? {1'b1, fb} : {1'b1, fa};
  assign my   = swap ? {1'b1, fa} : {1'b1, fb};
  assign d    = ex - ey;

  // Align the smaller operand: 3 extra bits (guard, round, sticky).
  assign wide_sh = {my, 32'd0} >> ((d > 8'd31) ? 5'd31 : d[4:0]);
  assign al      = {wide_sh[55:30], wide_sh[29] | (|wide_sh[28:0])};
  assign sum     = {1'b0, mx, 3'b000} + {1'b0, al};
  assign diff    = {mx, 3'b000} - al;
  assign eff_sub = sx ^ sy;

  // Leading-zero count of the difference: highest set bit wins.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (diff[i]) lz = 5'(26 - i);
    end
  end

  // Normalise to a 1.xxx mantissa with guard/round/sticky below it.
  always_comb begin
    n = 27'd0;
    e = 10'd0;
    if (eff_sub) begin
      n = diff << lz;
      e = {2'b00, ex} - {5'd0, lz};
    end else if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = {2'b00, ex} + 10'd1;
    end else begin
      n = sum[26:0];
      e = {2'b00, ex};
    end
  end

  // Round to nearest, ties to even.
  assign inc  = n[2] & (n[1] | n[0] | n[3]);
  assign mant = {1'b0, n[26:3]} + {24'd0, inc};
  assign e_r  = e + {9'd0, mant[24]};
  assign frac = mant[24] ? mant[23:1] : mant[22:0];

  // Special operands first, then overflow/underflow of the normal path.
  always_comb begin
    out = {sx, e_r[7:0], frac};
    if (a_nan || b_nan) begin
      out = QNAN;
    end else if (a_inf && b_inf) begin
      out = (sa != sb) ? QNAN : inA;
    end else if (a_inf) begin
      out = inA;
    end else if (b_inf) begin
      out = {sb, 8'hFF, 23'd0};
    end else if (a_zero) begin
      out = b_zero ? {sa & sb, 31'd0} : {sb, inB[30:0]};
    end else if (b_zero) begin
      out = inA;
    end else if (eff_sub && (diff == 27'd0)) begin
      out = 32'h0000_0000;
    end else if (!e_r[9] && (e_r >= 10'd255)) begin
      out = {sx, 8'hFF, 23'd0};
    end else if (e_r[9] || (e_r == 10'd0)) begin
      out = {sx, 31'd0};
    end
  end

endmodule

// File: tb/tb_fp_stream_accum.sv
// Testbench for fp_stream_accum: directed packets plus random integer-valued
// packets, with expected results queued at drive time and checked on output.

module tb_fp_stream_accum;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic             sum_valid;
  logic             sum_ready;
  logic [31:0]      sum_out;
  logic [CNT_W-1:0] sum_count;
  logic             sum_nan;
  logic             sum_inf;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic [31:0] nan;
    logic [31:0] inf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  fp_stream_accum #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_out   (sum_out),
    .sum_count (sum_count),
    .sum_nan   (sum_nan),
    .sum_inf   (sum_inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] s, input int c, input bit nan, input bit inf);
    exp_t e;
    e.sum = s;
    e.cnt = 32'(c);
    e.nan = 32'(nan);
    e.inf = 32'(inf);
    exp_q.push_back(e);
  endtask

  // Exact FP32 encoding of a small integer.
  function automatic logic [31:0] int_to_fp(input int v);
    int mag;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the element is taken.
  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL send_timeout: observed %0d cycles expected < 200", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("sent data=%h sub=%0b last=%0b", d, s, l);
  endtask

  // Scoreboard: a result is consumed on the edge where valid and ready meet.
  always @(negedge clk) begin
    exp_t e;
    if (sum_valid === 1'b1 && sum_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result: observed %h expected none", sum_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum_out", sum_out, e.sum);
        check("sum_count", 32'(sum_count), e.cnt);
        check("sum_nan", 32'(sum_nan), e.nan);
        check("sum_inf", 32'(sum_inf), e.inf);
        $display("result sum=%h count=%0d nan=%0b inf=%0b", sum_out, sum_count, sum_nan, sum_inf);
      end
    end
  end

  // Random consumer back-pressure.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      sum_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int len;
    int v;
    int n;
    bit s;
    bit l;

    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_sub = 1'b0; in_last = 1'b0;
    sum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_sum_out", sum_out, 32'd0);
    check("rst_sum_count", 32'(sum_count), 32'd0);
    check("rst_flags", {30'd0, sum_nan, sum_inf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: 1 + 2, with handshake timing
    push(32'h4040_0000, 2, 0, 0);
    send(32'h3F80_0000, 1'b0, 1'b0);
    check("t1_ready_add", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t1_ready_acc", 32'(in_ready), 32'd1);
    send(32'h4000_0000, 1'b0, 1'b1);
    check("t1_ready_add2", 32'(in_ready), 32'd0);
    check("t1_valid_add2", 32'(sum_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_out", 32'(sum_valid), 32'd1);
    check("t1_ready_out", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_pulse", 32'(sum_valid), 32'd0);

    // T2: 1 + 2 - 0.5, then a single-element subtract packet
    push(32'h4020_0000, 3, 0, 0);
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    send(32'h3F00_0000, 1'b1, 1'b1);
    push(32'hBFC0_0000, 1, 0, 0);
    send(32'h3FC0_0000, 1'b1, 1'b1);

    // T3: Inf and NaN propagation, flags cleared afterwards
    push(32'h7F80_0000, 2, 0, 1);
    send(32'h7F80_0000, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0, 1'b1);
    push(32'h7FAA_AAAA, 1, 1, 0);
    send(32'h7FC0_0000, 1'b0, 1'b1);
    push(32'h4040_0000, 1, 0, 0);
    send(32'h4040_0000, 1'b0, 1'b1);

    // T4: consumer stall with a waiting producer
    @(posedge clk); #1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    push(32'h4080_0000, 2, 0, 0);
    send(32'h4000_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_data = 32'h3F80_0000; in_sub = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_stall_valid", 32'(sum_valid), 32'd1);
      check("t4_stall_ready", 32'(in_ready), 32'd0);
      check("t4_stall_sum", sum_out, 32'h4080_0000);
      check("t4_stall_count", 32'(sum_count), 32'd2);
    end
    in_valid = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    push(32'h3F80_0000, 1, 0, 0);
    send(32'h3F80_0000, 1'b0, 1'b1);

    // T5: reset in the middle of a packet
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_sum_valid", 32'(sum_valid), 32'd0);
    check("t5_sum_out", sum_out, 32'd0);
    check("t5_sum_count", 32'(sum_count), 32'd0);
    check("t5_flags", {30'd0, sum_nan, sum_inf}, 32'd0);
    @(posedge clk); #1;
    push(32'h4000_0000, 1, 0, 0);
    send(32'h4000_0000, 1'b0, 1'b1);

    // T6: counter saturation, then random packets with random back-pressure
    push(32'h40A0_0000, 3, 0, 0);
    for (int i = 0; i < 5; i++) send(32'h3F80_0000, 1'b0, (i == 4));
    rand_ready = 1'b1;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 6);
      acc = 0;
      for (int i = 0; i < len; i++) begin
        v = int'($urandom_range(0, 16)) - 8;
        s = 1'($urandom_range(0, 1));
        l = (i == len - 1);
        acc = s ? acc - v : acc + v;
        if (l) push(int_to_fp(acc), (len > 3) ? 3 : len, 0, 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send(int_to_fp(v), s, l);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    sum_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
